// File: rtl/tpu_instr_issuer.sv
// Host-side sequencer for the TPU control unit: streams eight operand loads,
// waits out the compute window, issues four output reads and captures results.
module tpu_instr_issuer #(
    parameter int DW           = 8,
    parameter int RW           = 16,
    parameter int COMPUTE_WAIT = 8,
    parameter int READ_LAT     = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            abort,
    input  logic [4*DW-1:0] a_flat,
    input  logic [4*DW-1:0] b_flat,
    input  logic [RW-1:0]   result_in,
    output logic [7:0]      instrn,
    output logic [DW-1:0]   data_out,
    output logic            busy,
    output logic            done,
    output logic [4*RW-1:0] c_flat,
    output logic            c_valid
);

    localparam int WCW = (COMPUTE_WAIT < 2) ? 1 : $clog2(COMPUTE_WAIT);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_WAIT, S_READ, S_DRAIN, S_DONE
    } state_t;

    state_t            state_reg, state_next;
    logic [3:0]        cnt_reg, cnt_next;
    logic [WCW-1:0]    wait_reg, wait_next;
    logic [4*DW-1:0]   a_reg, a_next, b_reg, b_next;
    logic [7:0]        instrn_reg, instrn_next;
    logic [DW-1:0]     data_reg, data_next;
    logic              busy_reg, busy_next;
    logic              done_reg, done_next;
    logic              cvalid_reg, cvalid_next;
    logic [4*RW-1:0]   c_reg, c_next;

    // Stage k of the tracking pipe describes the read issued k cycles ago.
    logic [READ_LAT:0]     pipe_v_reg;
    logic [1:0]            pipe_s_reg [0:READ_LAT];
    logic                  push_v, pipe_clear, last_cap;
    logic [1:0]            push_s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= S_IDLE;
            cnt_reg    <= '0;
            wait_reg   <= '0;
            a_reg      <= '0;
            b_reg      <= '0;
            instrn_reg <= '0;
            data_reg   <= '0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
            cvalid_reg <= 1'b0;
            c_reg      <= '0;
            pipe_v_reg <= '0;
            for (int i = 0; i <= READ_LAT; i++) pipe_s_reg[i] <= '0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            wait_reg   <= wait_next;
            a_reg      <= a_next;
            b_reg      <= b_next;
            instrn_reg <= instrn_next;
            data_reg   <= data_next;
            busy_reg   <= busy_next;
            done_reg   <= done_next;
            cvalid_reg <= cvalid_next;
            c_reg      <= c_next;
            if (pipe_clear) begin
                pipe_v_reg <= '0;
                for (int i = 0; i <= READ_LAT; i++) pipe_s_reg[i] <= '0;
            end else begin
                pipe_v_reg    <= {pipe_v_reg[READ_LAT-1:0], push_v};
                pipe_s_reg[0] <= push_s;
                for (int i = 1; i <= READ_LAT; i++) pipe_s_reg[i] <= pipe_s_reg[i-1];
            end
        end
    end

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        wait_next   = wait_reg;
        a_next      = a_reg;
        b_next      = b_reg;
        instrn_next = 8'h00;
        data_next   = '0;
        busy_next   = busy_reg;
        done_next   = 1'b0;
        cvalid_next = cvalid_reg;
        c_next      = c_reg;
        push_v      = 1'b0;
        push_s      = 2'd0;
        pipe_clear  = 1'b0;
        last_cap    = 1'b0;

        if (pipe_v_reg[READ_LAT]) begin
            c_next[pipe_s_reg[READ_LAT]*RW +: RW] = result_in;
            last_cap = (pipe_s_reg[READ_LAT] == 2'd3);
        end

        case (state_reg)
            S_LOAD: begin
                if (cnt_reg < 4'd8) begin
                    instrn_next = {4'b0000, cnt_reg[1:0], cnt_reg[2], 1'b1};
                    data_next   = cnt_reg[2] ? b_reg[cnt_reg[1:0]*DW +: DW]
                                             : a_reg[cnt_reg[1:0]*DW +: DW];
                    cnt_next    = cnt_reg + 4'd1;
                end else begin
                    state_next = S_WAIT;
                    wait_next  = WCW'(COMPUTE_WAIT - 1);
                end
            end
            S_WAIT: begin
                if (wait_reg == '0) begin
                    instrn_next = 8'h10;
                    push_v      = 1'b1;
                    cnt_next    = 4'd1;
                    state_next  = S_READ;
                end else begin
                    wait_next = wait_reg - WCW'(1);
                end
            end
            S_READ: begin
                if (cnt_reg < 4'd4) begin
                    instrn_next = {1'b0, cnt_reg[1:0], 1'b1, 4'b0000};
                    push_v      = 1'b1;
                    push_s      = cnt_reg[1:0];
                    cnt_next    = cnt_reg + 4'd1;
                end else begin
                    state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (last_cap) begin
                    done_next   = 1'b1;
                    cvalid_next = 1'b1;
                    state_next  = S_DONE;
                end
            end
            S_DONE: begin
                busy_next  = 1'b0;
                state_next = S_IDLE;
            end
            default: ;
        endcase

        // A start presented while leaving the done cycle chains straight into a new sequence.
        if ((state_reg == S_IDLE || state_reg == S_DONE) && start) begin
            a_next      = a_flat;
            b_next      = b_flat;
            busy_next   = 1'b1;
            cvalid_next = 1'b0;
            instrn_next = 8'h01;
            data_next   = a_flat[DW-1:0];
            cnt_next    = 4'd1;
            state_next  = S_LOAD;
        end

        if (busy_reg && abort) begin
            state_next  = S_IDLE;
            instrn_next = 8'h00;
            data_next   = '0;
            busy_next   = 1'b0;
            done_next   = 1'b0;
            cvalid_next = cvalid_reg;
            c_next      = c_reg;
            a_next      = a_reg;
            b_next      = b_reg;
            push_v      = 1'b0;
            pipe_clear  = 1'b1;
        end
    end

    assign instrn   = instrn_reg;
    assign data_out = data_reg;
    assign busy     = busy_reg;
    assign done     = done_reg;
    assign c_flat   = c_reg;
    assign c_valid  = cvalid_reg;

endmodule

// File: tb/tb_tpu_instr_issuer.sv
// Bench for tpu_instr_issuer: a default instance and a short-wait/long-latency
// instance, each checked cycle by cycle against a schedule derived from timing rules.
module tb_tpu_instr_issuer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [31:0] a_flat = '0, b_flat = '0;
    logic [15:0] res_in0 = '0, res_in1 = '0;
    int          sel = 0;

    logic [7:0]  instrn0, instrn1, data0, data1;
    logic        busy0, busy1, done0, done1, cv0, cv1;
    logic [63:0] c0, c1;

    logic [7:0]  o_instrn, o_data;
    logic        o_busy, o_done, o_cv;
    logic [63:0] o_c;

    logic [63:0] cm [2];
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    tpu_instr_issuer u0 (
        .clk(clk), .rst_n(rst_n), .start(start && sel == 0), .abort(abort && sel == 0),
        .a_flat(a_flat), .b_flat(b_flat), .result_in(res_in0),
        .instrn(instrn0), .data_out(data0), .busy(busy0), .done(done0),
        .c_flat(c0), .c_valid(cv0));

    tpu_instr_issuer #(.COMPUTE_WAIT(2), .READ_LAT(3)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start && sel == 1), .abort(abort && sel == 1),
        .a_flat(a_flat), .b_flat(b_flat), .result_in(res_in1),
        .instrn(instrn1), .data_out(data1), .busy(busy1), .done(done1),
        .c_flat(c1), .c_valid(cv1));

    always_comb begin
        o_instrn = (sel == 1) ? instrn1 : instrn0;
        o_data   = (sel == 1) ? data1   : data0;
        o_busy   = (sel == 1) ? busy1   : busy0;
        o_done   = (sel == 1) ? done1   : done0;
        o_cv     = (sel == 1) ? cv1     : cv0;
        o_c      = (sel == 1) ? c1      : c0;
    end

    // One sequence on unit u. abort_at = edge index at which abort is sampled (-1: none).
    // hold keeps start high and stops after the done cycle; chained means start was already accepted.
    task automatic run_seq(input int u, input logic [31:0] a, input logic [31:0] b,
                           input int abort_at, input bit hold, input bit chained,
                           input bit fixed_res, input string tag);
        int cw, rl, dc, last, s;
        bit act;
        logic [15:0] res [4];
        logic [7:0]  e_instrn, e_data;
        logic        e_busy, e_done, e_cv;
        cw = (u == 1) ? 2 : 8;
        rl = (u == 1) ? 3 : 1;
        dc = 12 + cw + rl;
        last = hold ? dc : dc + 1;
        for (int k = 0; k < 4; k++) res[k] = fixed_res ? 16'(100 + k) : 16'($urandom);
        if (!chained) begin
            @(negedge clk);
            sel = u; a_flat = a; b_flat = b; start = 1'b1;
        end
        for (int n = 0; n <= last; n++) begin
            @(posedge clk); #1;
            if (!hold) start = 1'b0;
            act = (abort_at < 0) || (n < abort_at);
            e_instrn = 8'h00; e_data = 8'h00; e_busy = 1'b0; e_done = 1'b0;
            if (act && n <= dc) e_busy = 1'b1;
            if (act && n < 8) begin
                e_instrn = 8'(((n % 4) << 2) | ((n / 4) << 1) | 1);
                e_data   = (n < 4) ? a[(n % 4)*8 +: 8] : b[(n % 4)*8 +: 8];
            end
            if (act && n >= 8 + cw && n < 12 + cw) e_instrn = 8'(8'h10 | ((n - 8 - cw) << 5));
            if (act && n == dc) e_done = 1'b1;
            e_cv = act && (n >= dc);

            total++;
            if (o_instrn !== e_instrn) begin
                bad++; $display("FAIL %s cyc%0d instrn got=%h exp=%h", tag, n, o_instrn, e_instrn);
            end
            total++;
            if (o_data !== e_data) begin
                bad++; $display("FAIL %s cyc%0d data_out got=%h exp=%h", tag, n, o_data, e_data);
            end
            total++;
            if (o_busy !== e_busy) begin
                bad++; $display("FAIL %s cyc%0d busy got=%b exp=%b", tag, n, o_busy, e_busy);
            end
            total++;
            if (o_done !== e_done) begin
                bad++; $display("FAIL %s cyc%0d done got=%b exp=%b", tag, n, o_done, e_done);
            end
            total++;
            if (o_cv !== e_cv) begin
                bad++; $display("FAIL %s cyc%0d c_valid got=%b exp=%b", tag, n, o_cv, e_cv);
            end
            total++;
            if (o_c !== cm[u]) begin
                bad++; $display("FAIL %s cyc%0d c_flat got=%h exp=%h", tag, n, o_c, cm[u]);
            end

            // Operands may change freely once the start edge has passed.
            if (n == 3) a_flat = hold ? 32'h09090909 : $urandom;
            if (n == 3 && !hold) b_flat = $urandom;

            // Result for the read of cycle n-rl is presented in cycle n, sampled at edge n+1.
            s = n - rl - 8 - cw;
            if (s >= 0 && s < 4 && (abort_at < 0 || n - rl < abort_at)) begin
                if (u == 1) res_in1 = res[s]; else res_in0 = res[s];
                if (abort_at < 0 || n + 1 < abort_at) cm[u][s*16 +: 16] = res[s];
            end else begin
                if (u == 1) res_in1 = 16'($urandom); else res_in0 = 16'($urandom);
            end
            abort = (n + 1 == abort_at);
        end
        abort = 1'b0;
        $display("seq %s unit=%0d abort_at=%0d c_flat=%h", tag, u, abort_at, o_c);
    endtask

    task automatic test_reset();
        for (int u = 0; u < 2; u++) begin
            sel = u; #1;
            total++;
            if ({o_instrn, o_data, o_busy, o_done, o_cv} !== 19'd0 || o_c !== 64'd0) begin
                bad++;
                $display("FAIL reset unit%0d got instrn=%h data=%h busy=%b done=%b cv=%b c=%h exp all zero",
                         u, o_instrn, o_data, o_busy, o_done, o_cv, o_c);
            end
            $display("reset unit=%0d checked", u);
        end
    endtask

    task automatic test_load_read();
        run_seq(0, 32'h04030201, 32'h08070605, -1, 1'b0, 1'b0, 1'b1, "load_read");
        total++;
        if (c0 !== {16'd103, 16'd102, 16'd101, 16'd100}) begin
            bad++; $display("FAIL load_read final c_flat got=%h exp=%h", c0,
                            {16'd103, 16'd102, 16'd101, 16'd100});
        end
    endtask

    task automatic test_latency();
        run_seq(1, 32'h04030201, 32'h08070605, -1, 1'b0, 1'b0, 1'b0, "latency_fixed");
        for (int i = 0; i < 2; i++) run_seq(1, $urandom, $urandom, -1, 1'b0, 1'b0, 1'b0, "latency_rand");
    endtask

    task automatic test_back_to_back();
        logic [31:0] b;
        b = $urandom;
        run_seq(0, 32'h04030201, b, -1, 1'b1, 1'b0, 1'b0, "busy_first");
        run_seq(0, 32'h09090909, b, -1, 1'b0, 1'b1, 1'b0, "busy_second");
    endtask

    task automatic test_abort();
        run_seq(0, 32'h04030201, 32'h08070605, -1, 1'b0, 1'b0, 1'b1, "pre_abort");
        run_seq(0, 32'h04030201, 32'h08070605, 17, 1'b0, 1'b0, 1'b1, "abort17");
        total++;
        if (c0[15:0] !== 16'd100 || cv0 !== 1'b0) begin
            bad++; $display("FAIL abort17 slot0/c_valid got=%0d/%b exp=100/0", c0[15:0], cv0);
        end
        for (int i = 0; i < 8; i++) begin
            int u, dc, at;
            u  = int'($urandom_range(0, 1));
            dc = (u == 1) ? 17 : 21;
            at = (i % 4 == 3) ? -1 : int'($urandom_range(1, dc));
            run_seq(u, $urandom, $urandom, at, 1'b0, 1'b0, 1'b0, "abort_rand");
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        sel = 0; a_flat = $urandom; b_flat = $urandom; start = 1'b1;
        for (int n = 0; n <= 5; n++) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({instrn0, data0, busy0, done0, cv0} !== 19'd0 || c0 !== 64'd0) begin
            bad++;
            $display("FAIL async_reset got instrn=%h data=%h busy=%b done=%b cv=%b c=%h exp all zero",
                     instrn0, data0, busy0, done0, cv0, c0);
        end
        cm[0] = '0; cm[1] = '0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        $display("async_reset applied in cycle 5");
        run_seq(0, 32'h04030201, 32'h08070605, -1, 1'b0, 1'b0, 1'b1, "after_reset");
    endtask

    initial begin
        cm[0] = '0; cm[1] = '0;
        repeat (3) @(posedge clk);
        test_reset();
        @(negedge clk) rst_n = 1'b1;
        test_load_read();
        test_latency();
        test_back_to_back();
        test_abort();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
